router_ctrl_fsm: RTL and testbench

Control state machine for the 1x3 packet router input side. Decodes the 2-bit destination address of each incoming packet, waits for the target output FIFO to drain, and sequences the register stage through header, payload, FIFO-full stall, and parity phases. It drives the register stage's load/state strobes and the FIFO write enable, and raises `busy` to throttle the source.

---
 rtl/router_ctrl_fsm.sv | 113 +++++++++++
 tb/tb_router_ctrl_fsm.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/router_ctrl_fsm.sv
// Router input-side control FSM: address decode, drain wait, header/payload/stall/parity sequencing.
// Latency: Moore outputs, one clock after the causing input. Backpressure: busy holds the source; optional WTE watchdog under ROUTER_FSM_TIMEOUT_EN.
module router_ctrl_fsm #(
    parameter int TIMEOUT_CYCLES = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_packet_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy,
    output logic       drop_pkt
);

    typedef enum logic [2:0] {DA, LFD, LD, FFS, LAF, LP, CPE, WTE} state_t;

    state_t     state_q, state_d;
    logic [1:0] addr_q;
    logic [3:0] empty_vec, srst_vec;
    logic       sel_soft_reset;
    logic       timeout_hit;

    // Bit 3 pads address 3 so lookups never go out of range.
    assign empty_vec      = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign srst_vec       = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
    assign sel_soft_reset = srst_vec[addr_q];

`ifdef ROUTER_FSM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt;

    assign timeout_hit = (state_q == WTE) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt   <= '0;
            drop_pkt <= 1'b0;
        end else begin
            wd_cnt   <= (state_q == WTE && !timeout_hit) ? wd_cnt + 1'b1 : '0;
            drop_pkt <= timeout_hit && !sel_soft_reset;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
    assign drop_pkt       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            DA: begin
                if (pkt_valid && data_in != 2'd3)
                    state_d = empty_vec[data_in] ? LFD : WTE;
            end
            LFD: state_d = LD;
            LD: begin
                if (fifo_full)       state_d = FFS;
                else if (!pkt_valid) state_d = LP;
            end
            FFS: if (!fifo_full) state_d = LAF;
            LAF: begin
                if (parity_done)           state_d = DA;
                else if (low_packet_valid) state_d = LP;
                else                       state_d = LD;
            end
            LP:  state_d = CPE;
            CPE: state_d = fifo_full ? FFS : DA;
            WTE: if (empty_vec[addr_q]) state_d = LFD;
            default: state_d = DA;
        endcase
        // A flush of the selected port beats the watchdog, which beats normal flow.
        if (state_q != DA && sel_soft_reset) state_d = DA;
        else if (timeout_hit)                state_d = DA;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DA;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == DA && pkt_valid && data_in != 2'd3)
                addr_q <= data_in;
        end
    end

    assign detect_add    = (state_q == DA);
    assign lfd_state     = (state_q == LFD);
    assign ld_state      = (state_q == LD);
    assign laf_state     = (state_q == LAF);
    assign full_state    = (state_q == FFS);
    assign rst_int_reg   = (state_q == CPE);
    assign write_enb_reg = (state_q == LD) || (state_q == LP) || (state_q == LAF);
    assign busy          = !((state_q == DA) || (state_q == LD));

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Directed bench for router_ctrl_fsm; expected state patterns are hand-coded per step.
// Covers both builds of the optional watchdog.
module tb_router_ctrl_fsm;

    logic clock = 1'b0;
    logic reset, pkt_valid, fifo_full, parity_done, low_packet_valid;
    logic [1:0] data_in;
    logic fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic soft_reset_0, soft_reset_1, soft_reset_2;
    logic detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic write_enb_reg, busy, drop_pkt;

    int checks = 0;
    int failures = 0;
    int we_cnt = 0;

    // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
    localparam logic [7:0] S_DA  = 8'h80;
    localparam logic [7:0] S_LFD = 8'h41;
    localparam logic [7:0] S_LD  = 8'h22;
    localparam logic [7:0] S_LAF = 8'h13;
    localparam logic [7:0] S_FFS = 8'h09;
    localparam logic [7:0] S_CPE = 8'h05;
    localparam logic [7:0] S_LP  = 8'h03;
    localparam logic [7:0] S_WTE = 8'h01;

    always #5 clock = ~clock;

    router_ctrl_fsm #(.TIMEOUT_CYCLES(30)) dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_packet_valid(low_packet_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .rst_int_reg(rst_int_reg), .write_enb_reg(write_enb_reg),
        .busy(busy), .drop_pkt(drop_pkt)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] st, input logic drop);
        logic [8:0] obs, exp_v;
        obs   = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
                 write_enb_reg, busy, drop_pkt};
        exp_v = {st, drop};
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    initial begin
        reset = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        parity_done = 1'b0; low_packet_valid = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("reset", S_DA, 1'b0);

        // Address 3 is not a port: stay in DA.
        pkt_valid = 1'b1; data_in = 2'd3;
        tick(); check("addr3_da", S_DA, 1'b0);

        // Port 1, empty, 4 payload bytes.
        data_in = 2'd1;
        tick(); check("p1_lfd", S_LFD, 1'b0); we_cnt += int'(write_enb_reg);
        for (int i = 0; i < 4; i++) begin
            tick(); check("p1_ld", S_LD, 1'b0); we_cnt += int'(write_enb_reg);
        end
        pkt_valid = 1'b0;
        tick(); check("p1_lp", S_LP, 1'b0); we_cnt += int'(write_enb_reg);
        tick(); check("p1_cpe", S_CPE, 1'b0); we_cnt += int'(write_enb_reg);
        tick(); check("p1_da", S_DA, 1'b0); we_cnt += int'(write_enb_reg);
        checks++;
        assert (we_cnt == 5) else begin
            failures++;
            $error("FAIL p1_we_cycles observed=%0d expected=5", we_cnt);
        end

        // Port 2 not empty: WTE for 6 cycles, then LFD.
        fifo_empty_2 = 1'b0; pkt_valid = 1'b1; data_in = 2'd2;
        tick(); check("p2_wte0", S_WTE, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(); check("p2_wte", S_WTE, 1'b0);
        end
        fifo_empty_2 = 1'b1;
        tick(); check("p2_lfd", S_LFD, 1'b0);
        tick(); check("p2_ld", S_LD, 1'b0);

        // Full for 3 sampled cycles.
        fifo_full = 1'b1;
        tick(); check("ffs1", S_FFS, 1'b0);
        tick(); check("ffs2", S_FFS, 1'b0);
        tick(); check("ffs3", S_FFS, 1'b0);
        fifo_full = 1'b0;
        tick(); check("laf", S_LAF, 1'b0);
        tick(); check("laf_to_ld", S_LD, 1'b0);

        // pkt_valid drops as full rises: full wins, parity resolved from LAF.
        pkt_valid = 1'b0; fifo_full = 1'b1;
        tick(); check("full_wins", S_FFS, 1'b0);
        fifo_full = 1'b0; low_packet_valid = 1'b1;
        tick(); check("laf2", S_LAF, 1'b0);
        tick(); check("laf_to_lp", S_LP, 1'b0);
        low_packet_valid = 1'b0; fifo_full = 1'b1;
        tick(); check("lp_to_cpe", S_CPE, 1'b0);
        tick(); check("cpe_to_ffs", S_FFS, 1'b0);
        fifo_full = 1'b0;
        tick(); check("laf3", S_LAF, 1'b0);
        parity_done = 1'b1;
        tick(); check("laf_to_da", S_DA, 1'b0);
        parity_done = 1'b0;

        // Soft reset: only the selected port's flush matters.
        pkt_valid = 1'b1; data_in = 2'd0;
        tick(); check("p0_lfd", S_LFD, 1'b0);
        tick(); check("p0_ld", S_LD, 1'b0);
        soft_reset_1 = 1'b1;
        tick(); check("srst_other", S_LD, 1'b0);
        soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
        tick(); check("srst_sel", S_DA, 1'b0);
        soft_reset_0 = 1'b0; pkt_valid = 1'b0;

        // Watchdog on a port-0 packet that never drains.
        fifo_empty_0 = 1'b0; pkt_valid = 1'b1; data_in = 2'd0;
        tick(); check("to_wte0", S_WTE, 1'b0);
        pkt_valid = 1'b0;
`ifdef ROUTER_FSM_TIMEOUT_EN
        for (int i = 0; i < 29; i++) begin
            tick(); check("to_wte", S_WTE, 1'b0);
        end
        tick(); check("to_drop", S_DA, 1'b1);
        tick(); check("to_drop_clr", S_DA, 1'b0);
`else
        for (int i = 0; i < 99; i++) begin
            tick(); check("noto_wte", S_WTE, 1'b0);
        end
        soft_reset_0 = 1'b1;
        tick(); check("noto_srst", S_DA, 1'b0);
        soft_reset_0 = 1'b0;
        tick(); check("noto_da", S_DA, 1'b0);
`endif
        fifo_empty_0 = 1'b1;

        // Reset mid-packet.
        pkt_valid = 1'b1; data_in = 2'd1;
        tick(); check("r_lfd", S_LFD, 1'b0);
        tick(); check("r_ld", S_LD, 1'b0);
        reset = 1'b1;
        tick(); check("r_mid", S_DA, 1'b0);
        reset = 1'b0; pkt_valid = 1'b0;
        tick(); check("r_idle", S_DA, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
